// File: rtl/uart_tx_arbiter.sv
// Four-client arbiter feeding a single UART transmitter: grant, start pulse, then wait for eot or timeout.
// Define ARB_FIXED_PRIO_EN for fixed priority (client 0 highest); default is round-robin.
module uart_tx_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  req_i,
    input  logic [31:0] data_i,
    input  logic        eot_i,
    output logic [3:0]  gnt_o,
    output logic [7:0]  din_tx_o,
    output logic        sttx_o,
    output logic        busy_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT
    } state_t;

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [7:0]  din_q;
    logic [3:0]  gnt_q;
    logic        sttx_q;
    logic        busy_q;
    logic        err_q;
`ifndef ARB_FIXED_PRIO_EN
    logic [1:0]  last_q;
`endif

    logic        win_vld;
    logic [1:0]  win_idx;
    logic [7:0]  din_d;
    logic [3:0]  gnt_d;

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
`ifdef ARB_FIXED_PRIO_EN
        for (int unsigned k = 0; k < 4; k++) begin
            if (!win_vld && req_i[k[1:0]]) begin
                win_vld = 1'b1;
                win_idx = k[1:0];
            end
        end
`else
        // Offsets 1..4 from the last winner; offset 4 wraps back to the last winner itself.
        for (int unsigned k = 1; k <= 4; k++) begin
            if (!win_vld && req_i[last_q + k[1:0]]) begin
                win_vld = 1'b1;
                win_idx = last_q + k[1:0];
            end
        end
`endif
    end

    assign din_d = data_i[{win_idx, 3'b000} +: 8];
    assign gnt_d = 4'b0001 << win_idx;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            din_q   <= '0;
            gnt_q   <= '0;
            sttx_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            last_q  <= 2'd3;
`endif
        end else begin
            gnt_q  <= '0;
            sttx_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (win_vld) begin
                        state_q <= S_LOAD;
                        gnt_q   <= gnt_d;
                        din_q   <= din_d;
                        busy_q  <= 1'b1;
`ifndef ARB_FIXED_PRIO_EN
                        last_q  <= win_idx;
`endif
                    end
                end
                S_LOAD: begin
                    state_q <= S_START;
                    sttx_q  <= 1'b1;
                end
                S_START: begin
                    state_q <= S_WAIT;
                    cnt_q   <= '0;
                end
                S_WAIT: begin
                    // eot takes precedence over an expiring timeout in the same cycle.
                    if (eot_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == TIMEOUT - 16'd1) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_o    = gnt_q;
    assign din_tx_o = din_q;
    assign sttx_o   = sttx_q;
    assign busy_o   = busy_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-timeline reference model, per-cycle compare, directed literal checks.
module tb_uart_tx_arbiter;

    localparam int TMO = 20;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_i;
    logic [31:0] data_i;
    logic        eot_i;
    logic [3:0]  gnt_o;
    logic [7:0]  din_tx_o;
    logic        sttx_o;
    logic        busy_o;
    logic        err_o;

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;

    uart_tx_arbiter #(.TIMEOUT(16'd20)) dut (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .req_i   (req_i),
        .data_i  (data_i),
        .eot_i   (eot_i),
        .gnt_o   (gnt_o),
        .din_tx_o(din_tx_o),
        .sttx_o  (sttx_o),
        .busy_o  (busy_o),
        .err_o   (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic ck(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner chosen from the request vector and the previous winner.
    function automatic int pick(input logic [3:0] r, input int last);
        int w;
        w = -1;
`ifdef ARB_FIXED_PRIO_EN
        for (int k = 3; k >= 0; k--) if (r[k]) w = k;
`else
        for (int k = 4; k >= 1; k--) if (r[(last + k) % 4]) w = (last + k) % 4;
`endif
        return w;
    endfunction

    // Model: a transfer is a timeline anchored at the grant edge g.
    // Edge g: grant visible; g+1: start visible; g+2: wait begins; done on eot or TMO edges later.
    int       cyc = 0;
    int       g_edge = 0;
    int       m_win;
    int       m_last = 3;
    int       m_client = 0;
    bit       m_busy = 0;
    bit       m_err = 0;
    logic [7:0] m_byte = 8'h00;

    always_comb m_win = pick(req_i, m_last);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy   <= 0;
            m_err    <= 0;
            m_last   <= 3;
            m_client <= 0;
            m_byte   <= 8'h00;
        end else begin
            cyc   <= cyc + 1;
            m_err <= 0;
            if (!m_busy) begin
                if (m_win >= 0) begin
                    m_busy   <= 1;
                    g_edge   <= cyc + 1;
                    m_client <= m_win;
                    m_last   <= m_win;
                    m_byte   <= data_i[8*m_win +: 8];
                end
            end else if (cyc + 1 - g_edge >= 3) begin
                if (eot_i) begin
                    m_busy <= 0;
                end else if (cyc + 1 - (g_edge + 2) == TMO) begin
                    m_busy <= 0;
                    m_err  <= 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [3:0] e_gnt;
            logic       e_sttx;
            e_gnt  = (m_busy && (cyc - g_edge) == 0) ? (4'b0001 << m_client) : 4'b0000;
            e_sttx = m_busy && (cyc - g_edge) == 1;
            ck("gnt_o", 32'(gnt_o), 32'(e_gnt));
            ck("sttx_o", 32'(sttx_o), 32'(e_sttx));
            ck("busy_o", 32'(busy_o), 32'(m_busy));
            ck("err_o", 32'(err_o), 32'(m_err));
            ck("din_tx_o", 32'(din_tx_o), 32'(m_byte));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_gnt(output logic [3:0] g);
        g = 4'b0000;
        for (int i = 0; i < 40 && g == 4'b0000; i++) begin
            tick();
            g = gnt_o;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    logic [3:0] g;
    logic [3:0] pend;
    logic [7:0] bytes [4];

    initial begin
        rst_n  = 1'b1;
        req_i  = '0;
        data_i = '0;
        eot_i  = 1'b0;
        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        ck("rst_gnt", 32'(gnt_o), 32'h0);
        ck("rst_din", 32'(din_tx_o), 32'h0);
        ck("rst_sttx", 32'(sttx_o), 32'h0);
        ck("rst_busy", 32'(busy_o), 32'h0);
        ck("rst_err", 32'(err_o), 32'h0);
        chk_en = 1;
        rst_n  = 1'b1;
        tick();

        // Single request from client 2.
        req_i  = 4'b0100;
        data_i = 32'h0041_0000;
        tick();
        ck("single_gnt", 32'(gnt_o), 32'h4);
        ck("single_din", 32'(din_tx_o), 32'h41);
        ck("single_busy", 32'(busy_o), 32'h1);
        req_i = 4'b0000;
        tick();
        ck("single_sttx", 32'(sttx_o), 32'h1);
        ck("single_gnt_off", 32'(gnt_o), 32'h0);
        tick();
        repeat (9) tick();
        eot_i = 1'b1;
        tick();
        eot_i = 1'b0;
        ck("single_done_busy", 32'(busy_o), 32'h0);
        ck("single_din_hold", 32'(din_tx_o), 32'h41);

        // Contention: all four request at once.
        do_reset();
        req_i  = 4'b1111;
        data_i = 32'hD3C2_B1A0;
        for (int n = 0; n < 4; n++) begin
            wait_gnt(g);
`ifdef ARB_FIXED_PRIO_EN
            ck("contend_gnt", 32'(g), 32'h1);
`else
            ck("contend_gnt", 32'(g), 32'(4'b0001 << n));
            req_i = req_i & ~g;
`endif
            tick();
            tick();
            eot_i = 1'b1;
            tick();
            eot_i = 1'b0;
        end
        req_i = 4'b0000;
        tick();
        tick();

        // Timeout: no eot, err exactly TMO edges after entering wait.
        req_i  = 4'b0001;
        data_i = 32'h0000_005A;
        wait_gnt(g);
        ck("tmo_gnt", 32'(g), 32'h1);
        req_i = 4'b0000;
        tick();
        tick();
        for (int k = 1; k <= TMO; k++) begin
            tick();
            if (k == TMO - 1) begin
                ck("tmo_pre_err", 32'(err_o), 32'h0);
                ck("tmo_pre_busy", 32'(busy_o), 32'h1);
            end
        end
        ck("tmo_err", 32'(err_o), 32'h1);
        ck("tmo_busy", 32'(busy_o), 32'h0);
        tick();
        ck("tmo_err_pulse", 32'(err_o), 32'h0);

        // Race: eot on the final timeout cycle wins.
        req_i  = 4'b0010;
        data_i = 32'h0000_7700;
        wait_gnt(g);
        req_i = 4'b0000;
        tick();
        tick();
        repeat (TMO - 1) tick();
        eot_i = 1'b1;
        tick();
        eot_i = 1'b0;
        ck("race_err", 32'(err_o), 32'h0);
        ck("race_busy", 32'(busy_o), 32'h0);

        // Reset while waiting.
        req_i  = 4'b0100;
        data_i = 32'h0099_0000;
        wait_gnt(g);
        req_i = 4'b0000;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        ck("rstw_gnt", 32'(gnt_o), 32'h0);
        ck("rstw_din", 32'(din_tx_o), 32'h0);
        ck("rstw_sttx", 32'(sttx_o), 32'h0);
        ck("rstw_busy", 32'(busy_o), 32'h0);
        ck("rstw_err", 32'(err_o), 32'h0);
        tick();
        rst_n  = 1'b1;
        tick();
        req_i  = 4'b1000;
        data_i = 32'hE500_0000;
        wait_gnt(g);
        ck("rstw_post_gnt", 32'(g), 32'h8);
        ck("rstw_post_din", 32'(din_tx_o), 32'hE5);
        req_i = 4'b0000;
        tick();
        tick();
        eot_i = 1'b1;
        tick();
        eot_i = 1'b0;

        // Stray eot in idle.
        for (int n = 0; n < 5; n++) begin
            eot_i = 1'b1;
            tick();
            ck("stray_busy", 32'(busy_o), 32'h0);
            ck("stray_out", 32'({gnt_o, sttx_o, err_o}), 32'h0);
        end
        eot_i = 1'b0;

        // Randomized traffic; requesters hold until granted, sometimes re-request immediately.
        pend = 4'b0000;
        for (int k = 0; k < 4; k++) bytes[k] = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 4; k++) begin
                if (pend[k] && gnt_o[k]) begin
                    pend[k] = ($urandom_range(3) == 0);
                    if (pend[k]) bytes[k] = 8'($urandom);
                end else if (!pend[k] && $urandom_range(5) == 0) begin
                    pend[k]  = 1'b1;
                    bytes[k] = 8'($urandom);
                end
                data_i[8*k +: 8] = pend[k] ? bytes[k] : 8'($urandom);
            end
            req_i = pend;
            eot_i = ($urandom_range(9) == 0);
            tick();
        end
        req_i = 4'b0000;
        eot_i = 1'b1;
        repeat (6) tick();
        eot_i = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
